// File: rtl/mem_stage_ctrl.sv
// MEM-stage controller: splits 32-bit loads/stores into two 16-bit SRAM half-accesses.
// Optional sticky o_err output (both-request / misaligned) enabled by MEM_CTRL_ERR_EN.
module mem_stage_ctrl #(
    parameter logic [31:0] BASE_ADDR   = 32'd1024,
    parameter int unsigned WAIT_CYCLES = 2,
    parameter int unsigned SRAM_AW     = 18
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               i_rd_en,
    input  logic               i_wr_en,
    input  logic [31:0]        i_address,
    input  logic [31:0]        i_write_data,
    output logic [31:0]        o_read_data,
    output logic               o_ready,
    output logic [SRAM_AW-1:0] o_sram_addr,
    output logic [15:0]        o_sram_wdata,
    input  logic [15:0]        i_sram_rdata,
    output logic               o_sram_we_n,
    output logic               o_sram_oe_n
`ifdef MEM_CTRL_ERR_EN
    ,
    output logic               o_err
`endif
);

    localparam logic [3:0] LAST = 4'(WAIT_CYCLES - 1);

    typedef enum logic [1:0] {StIdle, StLow, StHigh, StDone} state_e;

    state_e             r_state, w_state_next;
    logic [3:0]         r_cnt, w_cnt_next;
    logic               r_is_wr, w_is_wr_next;
    logic [SRAM_AW-2:0] r_widx, w_widx_next;
    logic [31:0]        r_wbuf, w_wbuf_next;
    logic [15:0]        r_rlo, w_rlo_next;
    logic [31:0]        r_read_data, w_read_data_next;
    logic [SRAM_AW-1:0] r_sram_addr, w_sram_addr_next;
    logic [15:0]        r_sram_wdata, w_sram_wdata_next;
    logic               r_we_n, w_we_n_next;
    logic               r_oe_n, w_oe_n_next;

    logic               w_req;
    logic               w_last;
    logic               w_high;
    logic [31:0]        w_offset;
    logic [SRAM_AW-2:0] w_widx;
    logic               w_unused;

    assign w_req    = i_rd_en | i_wr_en;
    assign w_last   = (r_cnt == LAST);
    assign w_offset = i_address - BASE_ADDR;
    assign w_widx   = w_offset[SRAM_AW:2];
    assign w_unused = ^{w_offset[31:SRAM_AW+1], w_offset[1:0]};

    always_comb begin
        w_state_next     = r_state;
        w_cnt_next       = r_cnt;
        w_is_wr_next     = r_is_wr;
        w_widx_next      = r_widx;
        w_wbuf_next      = r_wbuf;
        w_rlo_next       = r_rlo;
        w_read_data_next = r_read_data;
        o_ready          = 1'b0;
        unique case (r_state)
            StIdle: begin
                o_ready = ~w_req;
                if (w_req) begin
                    w_is_wr_next = i_wr_en;
                    w_widx_next  = w_widx;
                    w_wbuf_next  = i_write_data;
                    w_cnt_next   = 4'd0;
                    w_state_next = StLow;
                end
            end
            StLow: begin
                if (w_last) begin
                    if (!r_is_wr) w_rlo_next = i_sram_rdata;
                    w_cnt_next   = 4'd0;
                    w_state_next = StHigh;
                end else begin
                    w_cnt_next = r_cnt + 4'd1;
                end
            end
            StHigh: begin
                if (w_last) begin
                    // Commit both halves together so an abandoned read never leaves a partial word.
                    if (!r_is_wr) w_read_data_next = {i_sram_rdata, r_rlo};
                    w_cnt_next   = 4'd0;
                    w_state_next = StDone;
                end else begin
                    w_cnt_next = r_cnt + 4'd1;
                end
            end
            StDone: begin
                o_ready      = 1'b1;
                w_state_next = StIdle;
            end
            default: w_state_next = StIdle;
        endcase
    end

    // Strobes are registered from the next state so they line up with the state they belong to.
    always_comb begin
        w_sram_addr_next  = r_sram_addr;
        w_sram_wdata_next = r_sram_wdata;
        w_we_n_next       = 1'b1;
        w_oe_n_next       = 1'b1;
        w_high            = (w_state_next == StHigh);
        if (w_state_next == StLow || w_state_next == StHigh) begin
            w_sram_addr_next = {w_widx_next, w_high};
            if (w_is_wr_next) begin
                w_sram_wdata_next = w_high ? w_wbuf_next[31:16] : w_wbuf_next[15:0];
                w_we_n_next       = (w_cnt_next == LAST);
            end else begin
                w_oe_n_next = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= StIdle;
            r_cnt        <= 4'd0;
            r_is_wr      <= 1'b0;
            r_widx       <= '0;
            r_wbuf       <= 32'd0;
            r_rlo        <= 16'd0;
            r_read_data  <= 32'd0;
            r_sram_addr  <= '0;
            r_sram_wdata <= 16'd0;
            r_we_n       <= 1'b1;
            r_oe_n       <= 1'b1;
        end else begin
            r_state      <= w_state_next;
            r_cnt        <= w_cnt_next;
            r_is_wr      <= w_is_wr_next;
            r_widx       <= w_widx_next;
            r_wbuf       <= w_wbuf_next;
            r_rlo        <= w_rlo_next;
            r_read_data  <= w_read_data_next;
            r_sram_addr  <= w_sram_addr_next;
            r_sram_wdata <= w_sram_wdata_next;
            r_we_n       <= w_we_n_next;
            r_oe_n       <= w_oe_n_next;
        end
    end

    assign o_read_data  = r_read_data;
    assign o_sram_addr  = r_sram_addr;
    assign o_sram_wdata = r_sram_wdata;
    assign o_sram_we_n  = r_we_n;
    assign o_sram_oe_n  = r_oe_n;

`ifdef MEM_CTRL_ERR_EN
    logic r_err;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_err <= 1'b0;
        end else if (r_state == StIdle && w_req &&
                     ((i_rd_en && i_wr_en) || i_address[1:0] != 2'b00)) begin
            r_err <= 1'b1;
        end
    end

    assign o_err = r_err;
`endif

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Directed, table-driven bench for mem_stage_ctrl with a small behavioural SRAM model.
module tb_mem_stage_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        i_rd_en = 1'b0;
    logic        i_wr_en = 1'b0;
    logic [31:0] i_address = 32'd0;
    logic [31:0] i_write_data = 32'd0;
    logic [31:0] o_read_data;
    logic        o_ready;
    logic [17:0] o_sram_addr;
    logic [15:0] o_sram_wdata;
    logic [15:0] i_sram_rdata;
    logic        o_sram_we_n;
    logic        o_sram_oe_n;
`ifdef MEM_CTRL_ERR_EN
    logic        o_err;
`endif

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    mem_stage_ctrl #(
        .BASE_ADDR   (32'd1024),
        .WAIT_CYCLES (2),
        .SRAM_AW     (18)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .i_rd_en      (i_rd_en),
        .i_wr_en      (i_wr_en),
        .i_address    (i_address),
        .i_write_data (i_write_data),
        .o_read_data  (o_read_data),
        .o_ready      (o_ready),
        .o_sram_addr  (o_sram_addr),
        .o_sram_wdata (o_sram_wdata),
        .i_sram_rdata (i_sram_rdata),
        .o_sram_we_n  (o_sram_we_n),
        .o_sram_oe_n  (o_sram_oe_n)
`ifdef MEM_CTRL_ERR_EN
        ,
        .o_err        (o_err)
`endif
    );

    // Behavioural SRAM, aliased on the low address byte.
    logic [15:0] mem [0:255];
    always @(posedge clk) begin
        if (!o_sram_we_n) mem[o_sram_addr[7:0]] <= o_sram_wdata;
    end
    assign i_sram_rdata = o_sram_oe_n ? 16'h0000 : mem[o_sram_addr[7:0]];

    typedef struct packed {
        logic        rd;
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic [3:0]  exp_we_low;
        logic [3:0]  exp_oe_low;
        logic [17:0] exp_a0;
        logic [17:0] exp_a1;
        logic [15:0] exp_w0;
        logic [15:0] exp_w1;
    } vec_t;

    vec_t vecs [10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Called just after a rising edge with the DUT in IDLE; returns just after the DONE edge.
    task automatic run_vec(input int idx, input vec_t v);
        int          rlow;
        int          we_low;
        int          oe_low;
        logic        first;
        logic [17:0] a0;
        logic [17:0] a1;
        logic [15:0] w0;
        logic [15:0] w1;
        rlow = 0; we_low = 0; oe_low = 0; first = 1'b1;
        a0 = '0; a1 = '0; w0 = '0; w1 = '0;
        i_rd_en = v.rd; i_wr_en = v.wr; i_address = v.addr; i_write_data = v.wdata;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (o_ready) break;
            rlow++;
            if (!o_sram_we_n || !o_sram_oe_n) begin
                if (first) a0 = o_sram_addr;
                first = 1'b0;
                a1 = o_sram_addr;
            end
            if (!o_sram_oe_n) oe_low++;
            if (!o_sram_we_n) begin
                we_low++;
                if (we_low == 1) w0 = o_sram_wdata;
                w1 = o_sram_wdata;
            end
        end
        check($sformatf("v%0d ready_low_cycles", idx), rlow, 5);
        check($sformatf("v%0d we_low_cycles", idx), we_low, {28'd0, v.exp_we_low});
        check($sformatf("v%0d oe_low_cycles", idx), oe_low, {28'd0, v.exp_oe_low});
        check($sformatf("v%0d lo_addr", idx), {14'd0, a0}, {14'd0, v.exp_a0});
        check($sformatf("v%0d hi_addr", idx), {14'd0, a1}, {14'd0, v.exp_a1});
        if (v.wr) begin
            check($sformatf("v%0d lo_wdata", idx), {16'd0, w0}, {16'd0, v.exp_w0});
            check($sformatf("v%0d hi_wdata", idx), {16'd0, w1}, {16'd0, v.exp_w1});
        end
        check($sformatf("v%0d done_strobes", idx), {30'd0, o_sram_we_n, o_sram_oe_n}, 32'd3);
        check($sformatf("v%0d read_data", idx), o_read_data, v.exp_rdata);
        @(posedge clk);
        #1;
        i_rd_en = 1'b0; i_wr_en = 1'b0;
    endtask

    initial begin
        logic [17:0] held_addr;

        //           rd    wr    addr         wdata          exp_rdata      we oe a0        a1        w0        w1
        vecs[0] = '{1'b0, 1'b1, 32'd1028, 32'hDEADBEEF, 32'h00000000, 4'd2, 4'd0, 18'd2, 18'd3,
                    16'hBEEF, 16'hDEAD};
        vecs[1] = '{1'b1, 1'b0, 32'd1028, 32'h0,        32'hDEADBEEF, 4'd0, 4'd4, 18'd2, 18'd3,
                    16'h0, 16'h0};
        vecs[2] = '{1'b0, 1'b1, 32'd1024, 32'h12345678, 32'hDEADBEEF, 4'd2, 4'd0, 18'd0, 18'd1,
                    16'h5678, 16'h1234};
        vecs[3] = '{1'b1, 1'b0, 32'd1024, 32'h0,        32'h12345678, 4'd0, 4'd4, 18'd0, 18'd1,
                    16'h0, 16'h0};
        vecs[4] = '{1'b0, 1'b1, 32'd1424, 32'h22221111, 32'h12345678, 4'd2, 4'd0, 18'd200, 18'd201,
                    16'h1111, 16'h2222};
        vecs[5] = '{1'b1, 1'b0, 32'd1424, 32'h0,        32'h22221111, 4'd0, 4'd4, 18'd200, 18'd201,
                    16'h0, 16'h0};
        vecs[6] = '{1'b0, 1'b1, 32'd0,    32'hCAFEF00D, 32'h22221111, 4'd2, 4'd0, 18'h3FE00,
                    18'h3FE01, 16'hF00D, 16'hCAFE};
        vecs[7] = '{1'b1, 1'b0, 32'd0,    32'h0,        32'hCAFEF00D, 4'd0, 4'd4, 18'h3FE00,
                    18'h3FE01, 16'h0, 16'h0};
        vecs[8] = '{1'b1, 1'b1, 32'd1026, 32'hA5A55A5A, 32'hCAFEF00D, 4'd2, 4'd0, 18'd0, 18'd1,
                    16'h5A5A, 16'hA5A5};
        vecs[9] = '{1'b1, 1'b0, 32'd1027, 32'h0,        32'hA5A55A5A, 4'd0, 4'd4, 18'd0, 18'd1,
                    16'h0, 16'h0};

        // Reset values.
        repeat (2) @(posedge clk);
        #1;
        check("reset ready", {31'd0, o_ready}, 32'd1);
        check("reset we_n/oe_n", {30'd0, o_sram_we_n, o_sram_oe_n}, 32'd3);
        check("reset sram_addr", {14'd0, o_sram_addr}, 32'd0);
        check("reset sram_wdata", {16'd0, o_sram_wdata}, 32'd0);
        check("reset read_data", o_read_data, 32'd0);
`ifdef MEM_CTRL_ERR_EN
        check("reset err", {31'd0, o_err}, 32'd0);
`endif
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Reset pulsed while the high half of a write is in progress.
        i_wr_en = 1'b1; i_address = 32'd1028; i_write_data = 32'hFFFF0000;
        repeat (3) @(posedge clk);
        #1;
        check("midwr in high we_n", {31'd0, o_sram_we_n}, 32'd0);
        check("midwr in high addr", {14'd0, o_sram_addr}, 32'd3);
        rst = 1'b1;
        i_wr_en = 1'b0;
        #1;
        check("midwr rst we_n", {31'd0, o_sram_we_n}, 32'd1);
        check("midwr rst ready", {31'd0, o_ready}, 32'd1);
        check("midwr rst read_data", o_read_data, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("midwr idle ready", {31'd0, o_ready}, 32'd1);
        check("midwr idle strobes", {30'd0, o_sram_we_n, o_sram_oe_n}, 32'd3);

        // Vectors 2 and 3 run back to back: the load is presented on the store's DONE edge.
        for (int i = 0; i < 10; i++) begin
`ifdef MEM_CTRL_ERR_EN
            if (i == 8) check("err before both-high", {31'd0, o_err}, 32'd0);
`endif
            run_vec(i, vecs[i]);
            if (i != 2) begin
                @(posedge clk);
                #1;
            end
`ifdef MEM_CTRL_ERR_EN
            if (i >= 8) check($sformatf("err sticky after v%0d", i), {31'd0, o_err}, 32'd1);
`endif
        end
        check("sram word0 lo", {16'd0, mem[0]}, 32'h00005A5A);
        check("sram word0 hi", {16'd0, mem[1]}, 32'h0000A5A5);

        // Ten idle cycles: nothing moves.
        held_addr = o_sram_addr;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            check($sformatf("idle%0d ready", c), {31'd0, o_ready}, 32'd1);
            check($sformatf("idle%0d strobes", c), {30'd0, o_sram_we_n, o_sram_oe_n}, 32'd3);
            check($sformatf("idle%0d addr", c), {14'd0, o_sram_addr}, {14'd0, held_addr});
        end
        check("idle read_data held", o_read_data, 32'hA5A55A5A);

`ifdef MEM_CTRL_ERR_EN
        @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check("err cleared by rst", {31'd0, o_err}, 32'd0);
        rst = 1'b0;
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/mem_stage_ctrl.md
Name: mem_stage_ctrl

Overview:
- Sequences the MEM-stage data access for the 5-stage ARM pipeline, driven by the EXE/MEM pipeline register outputs (MEM_R_EN, MEM_W_EN, ALU result as address, valRm as store data).
- Splits each 32-bit word access into two 16-bit accesses on an external asynchronous SRAM with a fixed wait count.
- Deasserts ready while busy so the hazard/freeze logic stalls all pipeline registers until the access completes.

Parameters:
- BASE_ADDR, 1024: byte address mapped to SRAM word 0.
- WAIT_CYCLES, 2: cycles per 16-bit half-access; legal range 2..15.
- SRAM_AW, 18: SRAM half-word address width.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- rd_en  in  1  load request (MEM_R_EN from EXE/MEM register).
- wr_en  in  1  store request (MEM_W_EN from EXE/MEM register).
- address  in  32  byte address (ALU result).
- write_data  in  32  store data (valRm).
- read_data  out  32  load result, valid from the DONE cycle onward.
- ready  out  1  high = pipeline may advance; low = freeze all stages.
- sram_addr  out  SRAM_AW  SRAM half-word address.
- sram_wdata  out  16  SRAM write data.
- sram_rdata  in  16  SRAM read data.
- sram_we_n  out  1  SRAM write strobe, active low.
- sram_oe_n  out  1  SRAM output enable, active low.

Behaviour:
- Reset values: state=IDLE, counter=0, read_data=0, sram_addr=0, sram_wdata=0, sram_we_n=1, sram_oe_n=1.
- Reset asserted mid-access: the access is abandoned immediately, with no partial read_data update.
- Word index: widx = (address - BASE_ADDR) >> 2, computed modulo 2^32 and truncated to SRAM_AW-1 bits. address[1:0] is ignored.
- Low half uses sram_addr = {widx, 0}; high half uses sram_addr = {widx, 1}.
- Operation latched in IDLE: op = write if wr_en, else read. When both are asserted, the write wins.
- FSM states: IDLE, LOW, HIGH, DONE. A 4-bit counter runs in LOW and HIGH.
- IDLE:
  - If (rd_en|wr_en), latch op, widx and write_data; counter=0; go to LOW.
  - Otherwise stay in IDLE.
- LOW:
  - Drive low-half address; drive sram_wdata = write_data[15:0] on a write.
  - When counter == WAIT_CYCLES-1: on a read, read_data[15:0] <= sram_rdata; counter=0; go to HIGH.
  - Otherwise counter++.
- HIGH: same as LOW using the high-half address and bits [31:16]; on the final count, go to DONE.
- DONE: no SRAM activity; go to IDLE next cycle.
- SRAM strobes:
  - sram_we_n is low during a write in LOW/HIGH for counter < WAIT_CYCLES-1. It is high on the last cycle of each half, giving data/address hold.
  - sram_oe_n is low throughout LOW/HIGH for reads, otherwise high.
  - Strobes are registered, i.e. derived from next state.
- ready (combinational):
  - 1 in DONE.
  - 1 in IDLE when !(rd_en|wr_en).
  - 0 in IDLE when a request is present, and 0 in LOW/HIGH.
- Latency: a request seen in IDLE holds ready=0 for exactly 1+2*WAIT_CYCLES cycles, then gives ready=1 for one DONE cycle.
- Back-to-back: the frozen request is still present in DONE. The pipeline advances on the DONE edge, and the next instruction's request is sampled in the following IDLE cycle. No double access occurs.
- Stability:
  - read_data holds its value until the next read completes; writes never alter it.
  - Request inputs changing during LOW/HIGH are ignored because they were latched in IDLE.

Optional Feature:
- Macro: MEM_CTRL_ERR_EN.
- Defined:
  - Adds output port err (1 bit, reset 0).
  - err is sticky-set when a request is sampled in IDLE with both rd_en and wr_en high, or with address[1:0] != 0.
  - err clears only on rst.
  - Arbitration and access behaviour are unchanged.
- Undefined: err port and its logic are absent; both-high silently performs a write; low address bits are silently ignored.

Test Plan:
- Reset mid-write (rst pulsed in HIGH, WAIT_CYCLES=2) -> next cycle state=IDLE, sram_we_n=1, ready=1 with no request, read_data unchanged.
- Write 0xDEADBEEF to address 1028, WAIT_CYCLES=2 -> sram_addr=2 with wdata 0xBEEF, then sram_addr=3 with 0xDEAD. we_n is low for 1 cycle per half. ready is low for 5 cycles, then high for 1.
- Read address 1028 with SRAM model holding 2:0xBEEF, 3:0xDEAD -> read_data=0xDEADBEEF in DONE. oe_n is low for 4 cycles; we_n stays 1.
- Back-to-back store to 1024 (0x12345678) then load from 1024 -> exactly two accesses, with one IDLE ready-low cycle between them. The load returns 0x12345678.
- rd_en=wr_en=1, address=1026, write_data=0xA5A5_5A5A -> write performed to sram_addr 0/1. With MEM_CTRL_ERR_EN, err=1 from the next cycle and stays 1 until rst.
- No request for 10 cycles -> ready=1, we_n=oe_n=1, sram_addr unchanged throughout.
